cordic_arbiter: RTL and testbench

- Shares the single cordic_sin_cos core between up to NUM_REQ requesters, e.g. the hour, minute, second and alarm hand renderers.
- Arbitration is round-robin. The block latches the winner's angle, sequences the core's start/done handshake, guards against a hung core with a timeout, and returns a tagged sine/cosine result to the winner.
- Sits between the hand-drawing logic and cordic_sin_cos, so renderers no longer own the core directly.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/cordic_arbiter_rr_picker.sv | 33 +++
 rtl/cordic_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cordic_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock-face CORDIC sharing logic.
// Requester angles are 9 bits wide, so inputs above 359 fold back with a single subtract.
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int DEG_FULL = 360;
   localparam int CORDIC_W = 16;
   localparam int ANG_W    = 9;

   function automatic logic [ANG_W-1:0] norm_angle(input logic [ANG_W-1:0] a);
      if (a >= ANG_W'(DEG_FULL)) begin
         return a - ANG_W'(DEG_FULL);
      end
      return a;
   endfunction

endpackage

// File: rtl/cordic_arbiter_rr_picker.sv
// Combinational round-robin select: first set request strictly after last_grant, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [ID_W-1:0]    grant,
   output logic               any_req
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   int idx;

   // Scan from the farthest candidate to the nearest so the nearest set bit is written last.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(last_grant) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req[idx[IW-1:0]]) begin
            grant   = ID_W'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end that time-shares one cordic_sin_cos core between hand renderers,
// with a minimum-latency mask for stale level-done and a hung-core timeout.
module cordic_arbiter
   import clock_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int MIN_LATENCY    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*9-1:0]   req_angle,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [CORDIC_W-1:0]    rsp_sin,
   output logic [CORDIC_W-1:0]    rsp_cos,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   cordic_start,
   output logic [CORDIC_W-1:0]    cordic_angle,
   input  logic [CORDIC_W-1:0]    cordic_sin,
   input  logic [CORDIC_W-1:0]    cordic_cos,
   input  logic                   cordic_done
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ID_W-1:0]      last_grant_q, last_grant_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [ANG_W-1:0]     angle_q, angle_d;
   logic [CORDIC_W-1:0]  cap_sin_q, cap_sin_d;
   logic [CORDIC_W-1:0]  cap_cos_q, cap_cos_d;
   logic                 cap_err_q, cap_err_d;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
   logic [CORDIC_W-1:0]  rsp_sin_q, rsp_sin_d;
   logic [CORDIC_W-1:0]  rsp_cos_q, rsp_cos_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 busy_q, busy_d;
   logic                 cordic_start_q, cordic_start_d;

   logic [ID_W-1:0]      pick_id;
   logic                 pick_any;
   logic [ANG_W-1:0]     ang_arr [NUM_REQ];
   logic                 done_ok;
   logic                 timed_out;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ang
      assign ang_arr[gi] = req_angle[gi*ANG_W +: ANG_W];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (pick_id),
      .any_req    (pick_any)
   );

   // A level done left over from the previous operation is still visible right after start.
   assign done_ok   = cordic_done && (int'(cnt_q) >= MIN_LATENCY - 1);
   assign timed_out = (int'(cnt_q) == TIMEOUT_CYCLES - 1);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      last_grant_d   = last_grant_q;
      id_d           = id_q;
      angle_d        = angle_q;
      cap_sin_d      = cap_sin_q;
      cap_cos_d      = cap_cos_q;
      cap_err_d      = cap_err_q;
      req_ready_d    = '0;
      rsp_valid_d    = 1'b0;
      rsp_id_d       = rsp_id_q;
      rsp_sin_d      = rsp_sin_q;
      rsp_cos_d      = rsp_cos_q;
      rsp_err_d      = 1'b0;
      cordic_start_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               id_d           = pick_id;
               angle_d        = norm_angle(ang_arr[pick_id]);
               req_ready_d    = NUM_REQ'(1) << pick_id;
               cordic_start_d = 1'b1;
               state_d        = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (done_ok) begin
               cap_sin_d = cordic_sin;
               cap_cos_d = cordic_cos;
               cap_err_d = 1'b0;
               state_d   = RESP;
            end else if (timed_out) begin
               cap_sin_d = '0;
               cap_cos_d = '0;
               cap_err_d = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = id_q;
            rsp_sin_d    = cap_sin_q;
            rsp_cos_d    = cap_cos_q;
            rsp_err_d    = cap_err_q;
            last_grant_d = id_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         last_grant_q   <= ID_W'(NUM_REQ - 1);
         id_q           <= '0;
         angle_q        <= '0;
         cap_sin_q      <= '0;
         cap_cos_q      <= '0;
         cap_err_q      <= 1'b0;
         req_ready_q    <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_sin_q      <= '0;
         rsp_cos_q      <= '0;
         rsp_err_q      <= 1'b0;
         busy_q         <= 1'b0;
         cordic_start_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         last_grant_q   <= last_grant_d;
         id_q           <= id_d;
         angle_q        <= angle_d;
         cap_sin_q      <= cap_sin_d;
         cap_cos_q      <= cap_cos_d;
         cap_err_q      <= cap_err_d;
         req_ready_q    <= req_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_sin_q      <= rsp_sin_d;
         rsp_cos_q      <= rsp_cos_d;
         rsp_err_q      <= rsp_err_d;
         busy_q         <= busy_d;
         cordic_start_q <= cordic_start_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_sin      = rsp_sin_q;
   assign rsp_cos      = rsp_cos_q;
   assign rsp_err      = rsp_err_q;
   assign busy         = busy_q;
   assign cordic_start = cordic_start_q;
   assign cordic_angle = {{(CORDIC_W-ANG_W){1'b0}}, angle_q};

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: round-robin order, angle folding, results, timeout and reset abort.
module tb_cordic_arbiter;

   localparam int N  = 4;
   localparam real PI = 3.14159265358979;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid = '0;
   logic [N*9-1:0]   req_angle = '0;
   logic [N-1:0]     req_ready;
   logic             rsp_valid;
   logic [1:0]       rsp_id;
   logic [15:0]      rsp_sin, rsp_cos;
   logic             rsp_err;
   logic             busy;
   logic             cordic_start;
   logic [15:0]      cordic_angle;
   logic [15:0]      cordic_sin = '0;
   logic [15:0]      cordic_cos = '0;
   logic             cordic_done = 1'b0;

   cordic_arbiter #(
      .NUM_REQ(N), .ID_W(2), .MIN_LATENCY(2), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos),
      .rsp_err(rsp_err), .busy(busy),
      .cordic_start(cordic_start), .cordic_angle(cordic_angle),
      .cordic_sin(cordic_sin), .cordic_cos(cordic_cos), .cordic_done(cordic_done)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          id;
      logic [15:0] s;
      logic [15:0] c;
      bit          err;
      int          lat;
   } rsp_t;

   int   grant_q[$];
   int   ang_q[$];
   rsp_t rsp_q[$];

   // Core behaviour knobs
   int lat        = 8;
   bit level_mode = 1'b0;
   bit hung       = 1'b0;

   // Requester state: remaining operations, angle list per operation
   int req_cnt[N];
   int rem[N];
   int used[N];
   int alist[N][8];
   int model_lg = N - 1;

   function automatic logic [15:0] ref_sin(input int a);
      real r;
      r = 16384.0 * $sin(real'(a) * PI / 180.0);
      return 16'($rtoi($floor(r + 0.5)));
   endfunction

   function automatic logic [15:0] ref_cos(input int a);
      real r;
      r = 16384.0 * $cos(real'(a) * PI / 180.0);
      return 16'($rtoi($floor(r + 0.5)));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural core: holds a level done for two cycles past a new start, then answers after lat cycles.
   initial begin
      int  t0;
      int  ang;
      bit  pend;
      pend = 1'b0;
      t0   = 0;
      ang  = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend        = 1'b0;
            cordic_done = 1'b0;
            cordic_sin  = '0;
            cordic_cos  = '0;
         end else begin
            if (cordic_start) begin
               pend = 1'b1;
               t0   = cyc;
               ang  = int'(cordic_angle);
            end
            if (pend && !hung && cyc == t0 + lat) begin
               cordic_done = 1'b1;
               cordic_sin  = ref_sin(ang);
               cordic_cos  = ref_cos(ang);
               pend        = 1'b0;
            end else if (!level_mode || (pend && cyc >= t0 + 2)) begin
               cordic_done = 1'b0;
            end
         end
      end
   end

   // Requesters: drop or re-request when req_ready is seen, presenting the next angle.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rem[i] > 0) begin
               rem[i]--;
               used[i]++;
            end
            req_valid[i] = (rem[i] > 0);
            req_angle[9*i +: 9] = (rem[i] > 0) ? 9'(alist[i][used[i]]) : 9'($urandom);
         end
      end
   end

   // Monitor: pops expectations whenever the DUT shows a grant, a start or a response.
   initial begin
      int   e;
      int   start_cyc;
      rsp_t r;
      start_cyc = 0;
      forever begin
         @(negedge clk);
         if (req_ready != '0) begin
            if (grant_q.size() == 0) begin
               total++; bad++;
               $display("FAIL grant: got unexpected req_ready=%b want none", req_ready);
            end else begin
               e = grant_q.pop_front();
               chk("grant", 32'(req_ready), 32'(1) << e);
            end
         end
         if (cordic_start) begin
            start_cyc = cyc;
            if (ang_q.size() == 0) begin
               total++; bad++;
               $display("FAIL start: got unexpected cordic_start want none");
            end else begin
               e = ang_q.pop_front();
               chk("cordic_angle", 32'(cordic_angle), 32'(e));
            end
         end
         if (rsp_valid) begin
            $display("rsp id=%0d sin=%0d cos=%0d err=%0d at cycle %0d",
                     rsp_id, $signed(rsp_sin), $signed(rsp_cos), rsp_err, cyc);
            if (rsp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rsp: got unexpected rsp_valid id=%0d want none", rsp_id);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_id",  32'(rsp_id),  32'(r.id));
               chk("rsp_sin", 32'(rsp_sin), 32'(r.s));
               chk("rsp_cos", 32'(rsp_cos), 32'(r.c));
               chk("rsp_err", 32'(rsp_err), 32'(r.err));
               chk("rsp_latency", 32'(cyc - start_cyc), 32'(r.lat));
            end
         end
      end
   end

   // Predict the grant sequence of a batch by plain round-robin over outstanding counts.
   task automatic run_batch(input bit expect_rsp);
      int   r[N];
      int   u[N];
      int   lg;
      int   c;
      int   a;
      int   ops;
      rsp_t x;
      ops = 0;
      for (int i = 0; i < N; i++) begin
         r[i] = req_cnt[i];
         u[i] = 0;
         ops += r[i];
      end
      lg = model_lg;
      for (int n = 0; n < ops; n++) begin
         c = -1;
         for (int k = 1; k <= N; k++) begin
            if (c < 0 && r[(lg + k) % N] > 0) c = (lg + k) % N;
         end
         a = alist[c][u[c]];
         u[c]++;
         r[c]--;
         grant_q.push_back(c);
         ang_q.push_back(a % 360);
         if (expect_rsp) begin
            x.id  = c;
            x.s   = hung ? 16'd0 : ref_sin(a % 360);
            x.c   = hung ? 16'd0 : ref_cos(a % 360);
            x.err = hung;
            x.lat = hung ? 66 : lat + 2;
            rsp_q.push_back(x);
         end
         lg = c;
      end
      model_lg = lg;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         used[i] = 0;
         rem[i]  = req_cnt[i];
      end
      if (expect_rsp) begin
         for (int t = 0; t < ops * 120 && (rsp_q.size() > 0 || grant_q.size() > 0); t++) begin
            @(negedge clk);
         end
         if (rsp_q.size() > 0 || grant_q.size() > 0) begin
            total++; bad++;
            $display("FAIL batch_timeout: got %0d responses outstanding want 0", rsp_q.size());
            grant_q.delete(); ang_q.delete(); rsp_q.delete();
         end
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic set_req(input int c0, input int c1, input int c2, input int c3);
      req_cnt[0] = c0; req_cnt[1] = c1; req_cnt[2] = c2; req_cnt[3] = c3;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; used[i] = 0; req_cnt[i] = 0;
         for (int j = 0; j < 8; j++) alist[i][j] = 0;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", 32'({req_ready, rsp_valid, rsp_err, busy, cordic_start}), 32'd0);
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      chk("reset_rsp_data", {rsp_sin, rsp_cos}, 32'd0);
      chk("reset_cordic_angle", 32'(cordic_angle), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single request, angle 90
      lat = 8;
      alist[0][0] = 90;
      set_req(1, 0, 0, 0);
      run_batch(1'b1);

      // Contention: everyone requesting, requester 0 twice
      lat = 6;
      alist[0][0] = 0; alist[0][1] = 0; alist[1][0] = 30; alist[2][0] = 180; alist[3][0] = 270;
      set_req(2, 1, 1, 1);
      run_batch(1'b1);

      // Wrap around last_grant=2 and fold 450 down to 90
      alist[2][0] = 45;
      set_req(0, 0, 1, 0);
      run_batch(1'b1);
      alist[1][0] = 200; alist[3][0] = 450;
      set_req(0, 1, 0, 1);
      run_batch(1'b1);

      // Level done held over from the previous result
      level_mode = 1'b1;
      lat = 5;
      alist[0][0] = 10; alist[1][0] = 100; alist[2][0] = 250;
      set_req(1, 1, 1, 0);
      run_batch(1'b1);
      level_mode = 1'b0;

      // Hung core then normal service
      hung = 1'b1;
      alist[1][0] = 60;
      set_req(0, 1, 0, 0);
      run_batch(1'b1);
      chk("busy_after_timeout", 32'(busy), 32'd0);
      hung = 1'b0;
      lat = 4;
      alist[0][0] = 300;
      set_req(1, 0, 0, 0);
      run_batch(1'b1);

      // Randomised batches
      for (int b = 0; b < 25; b++) begin
         lat        = $urandom_range(2, 12);
         level_mode = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) begin
            req_cnt[i] = $urandom_range(0, 2);
            for (int j = 0; j < 8; j++) alist[i][j] = $urandom_range(0, 511);
         end
         run_batch(1'b1);
      end
      level_mode = 1'b0;

      // Reset three cycles into WAIT
      lat = 10;
      alist[2][0] = 120;
      set_req(0, 0, 1, 0);
      run_batch(1'b0);
      for (int t = 0; t < 50 && !cordic_start; t++) @(negedge clk);
      chk("abort_start_seen", 32'(cordic_start), 32'd1);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_ctrl", 32'({req_ready, rsp_valid, rsp_err, busy, cordic_start}), 32'd0);
      chk("abort_rsp_data", {rsp_sin, rsp_cos}, 32'd0);
      chk("abort_cordic_angle", 32'(cordic_angle), 32'd0);
      for (int i = 0; i < N; i++) rem[i] = 0;
      grant_q.delete(); ang_q.delete(); rsp_q.delete();
      model_lg = N - 1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      alist[0][0] = 330; alist[2][0] = 15;
      set_req(1, 0, 1, 0);
      run_batch(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
